// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter (package riscv_defs).
package riscv_defs;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  // Command captured from the winning requester at grant time.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner selection between fetch and data requesters.
// With both requesting, the one that was not granted last wins; tying
// last to OWN_IF gives fixed data-over-fetch priority.
module mem_arb_pick
  import riscv_defs::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  arb_owner_t last,
  output arb_owner_t winner
);

  // Pick the winner from the live requests and the last-granted owner.
  always_comb begin
    winner = OWN_D;
    if (if_req && d_req) begin
      winner = (last == OWN_D) ? OWN_IF : OWN_D;
    end else if (if_req) begin
      winner = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port.
// Optional macro MEM_ARB_RR_EN: round-robin tie-break instead of data priority.
module mem_arbiter
  import riscv_defs::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            err
);

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  arb_state_t       state;
  arb_owner_t       owner;
  arb_owner_t       winner;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             any_req;
  logic             grant;
  logic             wait_done;
  logic             timeout;
  logic [XLEN-1:0]  resp_data;
  mem_cmd_t         sel_cmd;

`ifdef MEM_ARB_RR_EN
  arb_owner_t last;

  mem_arb_pick u_pick (
    .if_req (if_req),
    .d_req  (d_req),
    .last   (last),
    .winner (winner)
  );
`else
  mem_arb_pick u_pick (
    .if_req (if_req),
    .d_req  (d_req),
    .last   (OWN_IF),
    .winner (winner)
  );
`endif

  // Grants are combinational in IDLE and forced low while reset is held.
  assign any_req = if_req | d_req;
  assign grant   = !rst && (state == IDLE) && any_req;
  assign if_gnt  = grant && (winner == OWN_IF);
  assign d_gnt   = grant && (winner == OWN_D);

  // Command of the current winner; fetches are always reads.
  always_comb begin
    sel_cmd = '0;
    if (winner == OWN_D) begin
      sel_cmd.we    = d_we;
      sel_cmd.addr  = d_addr;
      sel_cmd.wdata = d_wdata;
    end else begin
      sel_cmd.we    = 1'b0;
      sel_cmd.addr  = if_addr;
      sel_cmd.wdata = '0;
    end
  end

  // WAIT exit: memory completion wins over a timeout in the same cycle.
  always_comb begin
    wait_cnt_inc = wait_cnt + CNT_W'(1);
    wait_done    = mem_ready || (wait_cnt_inc == WAIT_LIMIT);
    timeout      = !mem_ready;
    resp_data    = (mem_ready && !mem_we) ? mem_rdata : '0;
  end

  // Arbiter FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      err       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last      <= OWN_IF;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= WAIT;
            owner     <= winner;
            wait_cnt  <= '0;
            mem_req   <= 1'b1;
            mem_we    <= sel_cmd.we;
            mem_addr  <= sel_cmd.addr;
            mem_wdata <= sel_cmd.wdata;
`ifdef MEM_ARB_RR_EN
            last      <= winner;
`endif
          end
        end
        WAIT: begin
          if (wait_done) begin
            state   <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= timeout;
            if (owner == OWN_IF) begin
              if_rvalid <= 1'b1;
              if_rdata  <= resp_data;
            end else begin
              d_rvalid <= 1'b1;
              d_rdata  <= resp_data;
            end
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end
        RESP: begin
          state     <= IDLE;
          if_rvalid <= 1'b0;
          if_rdata  <= '0;
          d_rvalid  <= 1'b0;
          d_rdata   <= '0;
          err       <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MAX_WAIT = 15).
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        err;

  int checks;
  int errors;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_arbiter #(.MAX_WAIT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".if_gnt"},    32'(if_gnt),    32'd0);
    chk({tag, ".d_gnt"},     32'(d_gnt),     32'd0);
    chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, ".d_rvalid"},  32'(d_rvalid),  32'd0);
    chk({tag, ".if_rdata"},  if_rdata,       32'd0);
    chk({tag, ".d_rdata"},   d_rdata,        32'd0);
    chk({tag, ".mem_req"},   32'(mem_req),   32'd0);
    chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
    chk({tag, ".mem_addr"},  mem_addr,       32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, ".err"},       32'(err),       32'd0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_d;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if_req = 1'b1; if_addr = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    // Reset: everything zero, grants suppressed despite requests.
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    if_req = 1'b0; d_req = 1'b0;

    // Fetch only, first edge after release.
    @(negedge clk); rst = 1'b0; if_req = 1'b1; if_addr = 32'h10;
    #1 chk("f.if_gnt", 32'(if_gnt), 32'd1);
    chk("f.d_gnt", 32'(d_gnt), 32'd0);
    chk("f.mem_req_c0", 32'(mem_req), 32'd0);
    @(negedge clk); if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h00500093;
    #1 chk("f.mem_req_c1", 32'(mem_req), 32'd1);
    chk("f.mem_addr", mem_addr, 32'h10);
    chk("f.mem_we", 32'(mem_we), 32'd0);
    chk("f.if_gnt_wait", 32'(if_gnt), 32'd0);
    @(negedge clk); mem_ready = 1'b0; mem_rdata = '0;
    #1 chk("f.if_rvalid", 32'(if_rvalid), 32'd1);
    chk("f.if_rdata", if_rdata, 32'h00500093);
    chk("f.d_rvalid", 32'(d_rvalid), 32'd0);
    chk("f.err", 32'(err), 32'd0);
    chk("f.mem_req_c2", 32'(mem_req), 32'd0);
    @(negedge clk);
    #1 chk("f.if_rvalid_off", 32'(if_rvalid), 32'd0);

    // Simultaneous requests held over four transactions.
    for (int i = 0; i < 4; i++) begin
      exp_d = RR ? (i % 2 == 0) : 1'b1;
      if_req = 1'b1; if_addr = 32'h20 + 32'(i * 4);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300 + 32'(i * 4);
      #1 chk("arb.d_gnt", 32'(d_gnt), 32'(exp_d));
      chk("arb.if_gnt", 32'(if_gnt), 32'(!exp_d));
      @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hA0 + 32'(i);
      #1 chk("arb.mem_addr", mem_addr, exp_d ? 32'h300 + 32'(i * 4) : 32'h20 + 32'(i * 4));
      chk("arb.gnt_wait", 32'({if_gnt, d_gnt}), 32'd0);
      @(negedge clk); mem_ready = 1'b0;
      if (i == 3) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      #1 chk("arb.d_rvalid", 32'(d_rvalid), 32'(exp_d));
      chk("arb.if_rvalid", 32'(if_rvalid), 32'(!exp_d));
      chk("arb.rdata", exp_d ? d_rdata : if_rdata, 32'hA0 + 32'(i));
      @(negedge clk);
    end

    // Store 0xDEADBEEF to 0x100; store data comes back as 0.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    #1 chk("st.d_gnt", 32'(d_gnt), 32'd1);
    @(negedge clk); d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h12345678;
    #1 chk("st.mem_we", 32'(mem_we), 32'd1);
    chk("st.mem_addr", mem_addr, 32'h100);
    chk("st.mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk); mem_ready = 1'b0;
    #1 chk("st.d_rvalid", 32'(d_rvalid), 32'd1);
    chk("st.d_rdata", d_rdata, 32'd0);
    chk("st.mem_we_off", 32'(mem_we), 32'd0);

    // Load back from 0x100.
    @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    #1 chk("ld.d_gnt", 32'(d_gnt), 32'd1);
    @(negedge clk); d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1 chk("ld.mem_we", 32'(mem_we), 32'd0);
    @(negedge clk); mem_ready = 1'b0;
    #1 chk("ld.d_rvalid", 32'(d_rvalid), 32'd1);
    chk("ld.d_rdata", d_rdata, 32'hDEADBEEF);

    // Timeout: mem_req for exactly 15 cycles, then rdata 0 with err.
    @(negedge clk); d_req = 1'b1; d_addr = 32'h200;
    #1 chk("to.d_gnt", 32'(d_gnt), 32'd1);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); d_req = 1'b0; mem_rdata = 32'h55555555;
      #1 chk("to.mem_req", 32'(mem_req), 32'd1);
      chk("to.d_rvalid_wait", 32'(d_rvalid), 32'd0);
    end
    @(negedge clk);
    #1 chk("to.mem_req_drop", 32'(mem_req), 32'd0);
    chk("to.d_rvalid", 32'(d_rvalid), 32'd1);
    chk("to.d_rdata", d_rdata, 32'd0);
    chk("to.err", 32'(err), 32'd1);
    @(negedge clk);
    #1 chk("to.err_pulse", 32'(err), 32'd0);

    // Completion on the last allowed WAIT cycle wins over timeout.
    d_req = 1'b1; d_addr = 32'h204;
    #1 chk("bd.d_gnt", 32'(d_gnt), 32'd1);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk); d_req = 1'b0;
    end
    @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1 chk("bd.mem_req_last", 32'(mem_req), 32'd1);
    @(negedge clk); mem_ready = 1'b0;
    #1 chk("bd.d_rvalid", 32'(d_rvalid), 32'd1);
    chk("bd.d_rdata", d_rdata, 32'hCAFEF00D);
    chk("bd.err", 32'(err), 32'd0);

    // Reset mid-WAIT abandons the fetch; fresh request granted at once.
    @(negedge clk); if_req = 1'b1; if_addr = 32'h40;
    #1 chk("rw.if_gnt", 32'(if_gnt), 32'd1);
    @(negedge clk); if_req = 1'b0;
    #1 chk("rw.mem_req", 32'(mem_req), 32'd1);
    #1 rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h99999999;
    #1 chk_all_zero("rw.async");
    @(negedge clk);
    #1 chk("rw.if_rvalid", 32'(if_rvalid), 32'd0);
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0; if_req = 1'b1; if_addr = 32'h80;
    #1 chk("rw.fresh_gnt", 32'(if_gnt), 32'd1);
    chk("rw.if_rvalid2", 32'(if_rvalid), 32'd0);
    @(negedge clk); if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h11112222;
    #1 chk("rw.mem_addr", mem_addr, 32'h80);
    @(negedge clk); mem_ready = 1'b0;
    #1 chk("rw.if_rdata", if_rdata, 32'h11112222);
    chk("rw.if_rvalid3", 32'(if_rvalid), 32'd1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
